// File: rtl/cpu_pkg.sv
// cpu_pkg: shared format codes and immediate field widths for the CPU datapath.
package cpu_pkg;
    typedef logic [2:0] fmt_t;
    localparam fmt_t FMT_I   = 3'd0;
    localparam fmt_t FMT_S   = 3'd1;
    localparam fmt_t FMT_B   = 3'd2;
    localparam fmt_t FMT_U   = 3'd3;
    localparam fmt_t FMT_J   = 3'd4;
    localparam fmt_t FMT_RAW = 3'd5;
    localparam int XLEN_DEF = 32;
    localparam int IMM_W12  = 12;
    localparam int IMM_W13  = 13;
    localparam int IMM_W20  = 20;
    localparam int IMM_W21  = 21;
endpackage

// File: rtl/imm_field_sel.sv
// imm_field_sel: combinational immediate extraction by format, sign/zero extended to XLEN.
module imm_field_sel
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW_W = 12
) (
    input  logic [31:0]     instr_i,
    input  fmt_t            fmt_i,
    input  logic            zext_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);
    logic [31:0]     fld;
    logic [5:0]      w;
    logic            sgn;
    logic [XLEN-1:0] hi;
    always_comb begin
        fld = '0;
        w   = 6'(IMM_W12);
        sgn = instr_i[31];
        case (fmt_i)
            FMT_I:   fld = 32'(instr_i[31:20]);
            FMT_S:   fld = 32'({instr_i[31:25], instr_i[11:7]});
            FMT_B: begin
                fld = 32'({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0});
                w   = 6'(IMM_W13);
            end
            FMT_U: begin
                fld = {instr_i[31:12], 12'b0};
                w   = 6'(IMM_W20 + 12);
            end
            FMT_J: begin
                fld = 32'({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0});
                w   = 6'(IMM_W21);
            end
            FMT_RAW: begin
                fld = 32'(instr_i[RAW_W-1:0]);
                w   = 6'(RAW_W);
                sgn = instr_i[RAW_W-1];
            end
            default: ;
        endcase
    end
    // ones above the field width; a 32-bit field in a 32-bit result leaves nothing to fill
    assign hi        = ~((XLEN'(1) << w) - XLEN'(1));
    assign illegal_o = fmt_i > FMT_RAW;
    assign imm_o     = illegal_o ? '0 : (XLEN'(fld) | ((sgn & ~zext_i) ? hi : '0));
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender behind a valid/ready handshake with a skid entry.
module imm_ext_pipe
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW_W = 12
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INSTR,
    input  logic [2:0]      FMT,
    input  logic            ZEXT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] IMM,
    output logic            FMT_ERR
);
    logic [XLEN-1:0] new_imm, out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic            new_err, out_err_q, out_err_d, skid_err_q, skid_err_d;
    logic            out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic            in_xfer, load_out, take_skid;

    imm_field_sel #(.XLEN(XLEN), .RAW_W(RAW_W)) u_sel (
        .instr_i  (INSTR),
        .fmt_i    (FMT),
        .zext_i   (ZEXT),
        .imm_o    (new_imm),
        .illegal_o(new_err)
    );

    assign in_xfer   = IN_VALID & ~skid_vld_q;
    assign load_out  = ~out_vld_q | OUT_READY;
    assign take_skid = ~FLUSH & ~load_out & in_xfer;

    always_comb begin
        out_vld_d  = FLUSH ? 1'b0 : load_out ? (skid_vld_q | in_xfer) : 1'b1;
        out_imm_d  = (FLUSH | ~load_out) ? out_imm_q : skid_vld_q ? skid_imm_q : in_xfer ? new_imm : out_imm_q;
        out_err_d  = (FLUSH | ~load_out) ? out_err_q : skid_vld_q ? skid_err_q : in_xfer ? new_err : out_err_q;
        skid_vld_d = FLUSH ? 1'b0 : load_out ? 1'b0 : (skid_vld_q | in_xfer);
        skid_imm_d = take_skid ? new_imm : skid_imm_q;
        skid_err_d = take_skid ? new_err : skid_err_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_vld_q  <= 1'b0;
            out_imm_q  <= '0;
            out_err_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_imm_q  <= out_imm_d;
            out_err_q  <= out_err_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_err_q <= skid_err_d;
        end
    end

    assign IN_READY  = ~skid_vld_q;
    assign OUT_VALID = out_vld_q;
    assign IMM       = out_imm_q;
    assign FMT_ERR   = out_err_q;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: scoreboard bench for imm_ext_pipe (XLEN=32 checked via queue, XLEN=64 spot-checked).
module tb_imm_ext_pipe;
    typedef struct packed { logic [31:0] imm; logic err; } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] instr = '0;
    logic [2:0]  fmt = '0;
    logic        zext = 1'b0;
    logic        in_ready, out_valid, fmt_err;
    logic [31:0] imm;
    logic        in_ready64, out_valid64, fmt_err64;
    logic [63:0] imm64;
    exp_t        q[$];
    exp_t        mon_e;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32)) dut (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
        .INSTR(instr), .FMT(fmt), .ZEXT(zext), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .IMM(imm), .FMT_ERR(fmt_err)
    );

    imm_ext_pipe #(.XLEN(64)) u64 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready64),
        .INSTR(instr), .FMT(fmt), .ZEXT(zext), .OUT_VALID(out_valid64), .OUT_READY(out_ready),
        .IMM(imm64), .FMT_ERR(fmt_err64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // outputs and OUT_READY are stable from the falling edge to the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got imm %h err %b, expected nothing", imm, fmt_err);
            end else begin
                mon_e = q.pop_front();
                chk("out_imm", 64'(imm), 64'(mon_e.imm));
                chk("out_err", 64'(fmt_err), 64'(mon_e.err));
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [2:0] f, input logic z,
                        input logic [31:0] ei, input logic ee, input bit push);
        int  k = 0;
        bit  ok;
        instr = ins; fmt = f; zext = z; in_valid = 1'b1;
        if (push) q.push_back('{imm: ei, err: ee});
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!ok && k < 50);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", 64'(imm), 64'd0);
        chk("rst_err", 64'(fmt_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(32'hFFF00093, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1);
        chk("latency_valid", 64'(out_valid), 64'd1);
        send(32'hFFF00093, 3'd0, 1'b1, 32'h00000FFF, 1'b0, 1);
        send(32'hFE112E23, 3'd1, 1'b0, 32'hFFFFFFFC, 1'b0, 1);
        send(32'hFE000EE3, 3'd2, 1'b0, 32'hFFFFFFFC, 1'b0, 1);
        send(32'hFF9FF06F, 3'd4, 1'b0, 32'hFFFFFFF8, 1'b0, 1);
        send(32'hFF9FF06F, 3'd4, 1'b1, 32'h001FFFF8, 1'b0, 1);
        send(32'h12345037, 3'd3, 1'b0, 32'h12345000, 1'b0, 1);
        send(32'h80000037, 3'd3, 1'b0, 32'h80000000, 1'b0, 1);
        chk("u64_imm", imm64, 64'hFFFFFFFF80000000);
        send(32'h00000ABC, 3'd5, 1'b0, 32'hFFFFFABC, 1'b0, 1);
        send(32'h00000ABC, 3'd5, 1'b1, 32'h00000ABC, 1'b0, 1);
        send(32'hFFFFFFFF, 3'd7, 1'b0, 32'h00000000, 1'b1, 1);
        send(32'h00100093, 3'd0, 1'b0, 32'h00000001, 1'b0, 1);
        send(32'h12345678, 3'd6, 1'b1, 32'h00000000, 1'b1, 1);
        send(32'h00200093, 3'd0, 1'b0, 32'h00000002, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;

        // stall: A held in output, B in skid, C held off
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 1'b0, 32'd1, 1'b0, 1);
        send(32'h00200093, 3'd0, 1'b0, 32'd2, 1'b0, 1);
        instr = 32'h00300093; fmt = 3'd0; zext = 1'b0; in_valid = 1'b1;
        q.push_back('{imm: 32'd3, err: 1'b0});
        repeat (2) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_imm", 64'(imm), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h00300093, 3'd0, 1'b0, 32'd3, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;

        // flush with both entries full and a new input presented
        out_ready = 1'b0;
        send(32'h00500093, 3'd0, 1'b0, 32'd5, 1'b0, 0);
        send(32'h00600093, 3'd0, 1'b0, 32'd6, 1'b0, 0);
        instr = 32'h00700093; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        // flush with only the output full: an acceptable input must still be dropped
        send(32'h00800093, 3'd0, 1'b0, 32'd8, 1'b0, 0);
        instr = 32'h00900093; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", 64'(out_valid), 64'd0);
        chk("flush2_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_stays_empty", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // asynchronous reset mid-stall
        out_ready = 1'b0;
        send(32'h00500093, 3'd0, 1'b0, 32'd5, 1'b0, 0);
        send(32'hFFF00093, 3'd7, 1'b0, 32'd0, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_imm", 64'(imm), 64'd0);
        chk("arst_err", 64'(fmt_err), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h00300093, 3'd0, 1'b1, 32'd3, 1'b0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
